// File: rtl/cpu_mem_responder_pkg.sv
// Shared bus definitions for the cpu_core memory responder: I/O register offsets,
// STATUS bit positions, FSM states, unmapped read value and the boot ROM image.
package cpu_mem_responder_pkg;

   localparam logic [1:0] REG_PORT   = 2'd0;
   localparam logic [1:0] REG_TIMER  = 2'd1;
   localparam logic [1:0] REG_RELOAD = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   localparam int ST_FLAG = 0;
   localparam int ST_IE   = 1;

   localparam logic [7:0] UNMAPPED_RD = 8'hFF;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   // Boot image: reset vector $FFFC/$FFFD points at $F000, filler elsewhere.
   function automatic logic [7:0] rom_image(input logic [15:0] a);
      case (a)
         16'hFFFC: return 8'h00;
         16'hFFFD: return 8'hF0;
         default:  return a[7:0] ^ a[15:8];
      endcase
   endfunction

endpackage

// File: rtl/cpu_mem_responder_io_timer8.sv
// 8-bit free-running timer with reload, sticky wrap flag and irq enable.
// Register writes take effect at the strobing edge; irq is a combinational AND of registered bits.
module cpu_mem_responder_io_timer8 (
   input  logic       clk,
   input  logic       reset,
   input  logic       count_we,
   input  logic [7:0] count_d,
   input  logic       reload_we,
   input  logic [7:0] reload_d,
   input  logic       status_we,
   input  logic       flag_clr,
   input  logic       ie_d,
   output logic [7:0] count,
   output logic [7:0] reload,
   output logic       flag,
   output logic       ie,
   output logic       irq
);

   logic wrap;
   assign wrap = (count == 8'hFF);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count  <= 8'h00;
         reload <= 8'h00;
         flag   <= 1'b0;
         ie     <= 1'b0;
      end else begin
         // A software load wins over the wrap, but the wrap still raises the flag.
         if (count_we)  count <= count_d;
         else if (wrap) count <= reload;
         else           count <= count + 8'd1;

         if (wrap)                       flag <= 1'b1;
         else if (status_we && flag_clr) flag <= 1'b0;

         if (status_we) ie     <= ie_d;
         if (reload_we) reload <= reload_d;
      end
   end

   assign irq = flag & ie;

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory/bus responder for cpu_core: RAM, boot ROM and a 4-register I/O page on one req/rdy port.
// RAM/IO reads return next cycle with rdy held high; ROM reads drop rdy for ROM_WAIT cycles.
module cpu_mem_responder
   import cpu_mem_responder_pkg::*;
#(
   parameter int         RAM_AW   = 11,
   parameter int         ROM_AW   = 12,
   parameter int         ROM_WAIT = 1,
   parameter logic [7:0] IO_PAGE  = 8'hD0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] addr,
   input  logic        req,
   input  logic        we,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   output logic        rdy,
   output logic [7:0]  port_out,
   output logic        timer_irq,
   output logic        bus_err
);

   localparam logic [16:0] RAM_TOP  = 17'(2 ** RAM_AW);
   localparam logic [16:0] ROM_BASE = 17'(2 ** 16 - 2 ** ROM_AW);
   localparam logic [2:0]  WAIT_LD  = 3'(ROM_WAIT - 1);

   logic [7:0]  ram [2 ** RAM_AW];
   state_t      state;
   logic [2:0]  wcnt;
   logic [15:0] rom_addr;

   logic        accept, ram_hit, io_hit, rom_hit, io_we;
   logic [7:0]  io_rd, status_rd, tmr_count, tmr_reload;
   logic        tmr_flag, tmr_ie;

   assign accept  = req & rdy;
   assign ram_hit = {1'b0, addr} < RAM_TOP;
   assign io_hit  = !ram_hit && (addr[15:8] == IO_PAGE) && (addr[7:0] < 8'd4);
   assign rom_hit = !ram_hit && !io_hit && ({1'b0, addr} >= ROM_BASE);
   assign io_we   = accept & we & io_hit;

   cpu_mem_responder_io_timer8 u_timer (
      .clk       (clk),
      .reset     (reset),
      .count_we  (io_we && addr[1:0] == REG_TIMER),
      .count_d   (wdata),
      .reload_we (io_we && addr[1:0] == REG_RELOAD),
      .reload_d  (wdata),
      .status_we (io_we && addr[1:0] == REG_STATUS),
      .flag_clr  (wdata[ST_FLAG]),
      .ie_d      (wdata[ST_IE]),
      .count     (tmr_count),
      .reload    (tmr_reload),
      .flag      (tmr_flag),
      .ie        (tmr_ie),
      .irq       (timer_irq)
   );

   always_comb begin
      status_rd          = 8'h00;
      status_rd[ST_FLAG] = tmr_flag;
      status_rd[ST_IE]   = tmr_ie;
      case (addr[1:0])
         REG_PORT:   io_rd = port_out;
         REG_TIMER:  io_rd = tmr_count;
         REG_RELOAD: io_rd = tmr_reload;
         default:    io_rd = status_rd;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept && we && ram_hit) ram[addr[RAM_AW-1:0]] <= wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         rdy      <= 1'b1;
         rdata    <= 8'h00;
         bus_err  <= 1'b0;
         wcnt     <= 3'd0;
         rom_addr <= 16'h0000;
         port_out <= 8'h00;
      end else begin
         bus_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (ram_hit) begin
                     if (!we) rdata <= ram[addr[RAM_AW-1:0]];
                  end else if (io_hit) begin
                     if (!we)                           rdata    <= io_rd;
                     else if (addr[1:0] == REG_PORT)    port_out <= wdata;
                  end else if (rom_hit) begin
                     if (we)                 bus_err <= 1'b1;
                     else if (ROM_WAIT == 0) rdata   <= rom_image(addr);
                     else begin
                        state    <= S_WAIT;
                        rdy      <= 1'b0;
                        wcnt     <= WAIT_LD;
                        rom_addr <= addr;
                     end
                  end else begin
                     bus_err <= 1'b1;
                     if (!we) rdata <= UNMAPPED_RD;
                  end
               end
            end
            S_WAIT: begin
               if (wcnt == 3'd0) begin
                  rdata <= rom_image(rom_addr);
                  rdy   <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  wcnt <= wcnt - 3'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
